// File: rtl/frag_write_buffer_pkg.sv
// Shared widths, screen size, FSM encoding and fragment payload for frag_write_buffer.
// The optional FRAG_CLIP_EN build uses on_screen() to discard off-screen fragments.
package frag_write_buffer_pkg;

    localparam int unsigned DEPTH_LOG2 = 3;
    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned C_W        = 3;
    localparam int unsigned SCR_W      = 160;
    localparam int unsigned SCR_H      = 120;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
    } frag_t;

    function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (x < X_W'(SCR_W)) && (y < Y_W'(SCR_H));
    endfunction

endpackage

// File: rtl/frag_write_buffer_if.sv
// Fragment source, VGA write port and frame status signals of frag_write_buffer.
// slave = the buffer itself, master = the surrounding draw unit / adapter side.
interface frag_write_buffer_if;
    import frag_write_buffer_pkg::*;

    logic             frame_start;
    logic [X_W-1:0]   src_x;
    logic [Y_W-1:0]   src_y;
    logic [C_W-1:0]   src_colour;
    logic             src_plot;
    logic             src_finished;
    logic [X_W-1:0]   vga_x;
    logic [Y_W-1:0]   vga_y;
    logic [C_W-1:0]   vga_colour;
    logic             vga_plot;
    logic             vga_ready;
    logic             frame_done;
    logic             busy;
    logic             overflow;
    logic [CNT_W-1:0] frag_count;

    modport slave (
        input  frame_start, src_x, src_y, src_colour, src_plot, src_finished, vga_ready,
        output vga_x, vga_y, vga_colour, vga_plot, frame_done, busy, overflow, frag_count
    );

    modport master (
        output frame_start, src_x, src_y, src_colour, src_plot, src_finished, vga_ready,
        input  vga_x, vga_y, vga_colour, vga_plot, frame_done, busy, overflow, frag_count
    );
endinterface

// File: rtl/frag_fifo.sv
// Synchronous FIFO of fragments; extra pointer MSB distinguishes full from empty.
// Head is read combinationally from the registered memory.
module frag_fifo
    import frag_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2_P = DEPTH_LOG2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  frag_t din_i,
    input  logic  pop_i,
    output frag_t head_c,
    output logic  full_c,
    output logic  empty_c
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2_P;
    localparam int unsigned PTR_W = DEPTH_LOG2_P + 1;

    frag_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q[DEPTH_LOG2_P-1:0]] <= din_i;
    end

    assign head_c  = mem_q[rd_ptr_q[DEPTH_LOG2_P-1:0]];
    assign empty_c = (wr_ptr_q == rd_ptr_q);
    assign full_c  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
endmodule

// File: rtl/frag_write_buffer.sv
// Buffers draw-unit fragments and drains them to the VGA write port, tracking frame completion.
// Optional macro FRAG_CLIP_EN discards fragments outside the SCR_W x SCR_H screen.
module frag_write_buffer
    import frag_write_buffer_pkg::*;
(
    input logic                clock,
    input logic                resetn,
    frag_write_buffer_if.slave bus
);
    frag_t            head_c;
    logic             full_c;
    logic             empty_c;
    logic             clip_ok_c;
    logic             load_c;
    logic             pop_c;
    logic             push_c;
    logic             drop_c;
    logic             xfer_c;

    frag_t            vga_q;
    logic             vga_plot_q;
    state_e           state_q;
    logic             fill_first_q;
    logic             frame_done_q;
    logic             busy_q;
    logic             overflow_q;
    logic [CNT_W-1:0] frag_count_q;

`ifdef FRAG_CLIP_EN
    assign clip_ok_c = on_screen(bus.src_x, bus.src_y);
`else
    assign clip_ok_c = 1'b1;
`endif

    // Output register reloads whenever it is empty or its write is being accepted.
    assign load_c = !vga_plot_q || bus.vga_ready;
    assign pop_c  = load_c && !empty_c;
    assign push_c = bus.src_plot && clip_ok_c && (!full_c || pop_c);
    assign drop_c = bus.src_plot && clip_ok_c && full_c && !pop_c;
    assign xfer_c = vga_plot_q && bus.vga_ready;

    frag_fifo #(.DEPTH_LOG2_P(DEPTH_LOG2)) u_fifo (
        .clk     (clock),
        .rst_n   (resetn),
        .push_i  (push_c),
        .din_i   ({bus.src_x, bus.src_y, bus.src_colour}),
        .pop_i   (pop_c),
        .head_c  (head_c),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            vga_q      <= '0;
            vga_plot_q <= 1'b0;
        end else if (load_c) begin
            vga_plot_q <= !empty_c;
            if (!empty_c) vga_q <= head_c;
        end
    end

    // Frame FSM with sticky overflow and saturating write counter.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            fill_first_q <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            frag_count_q <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (drop_c) overflow_q <= 1'b1;
            if (xfer_c && (frag_count_q != '1)) frag_count_q <= frag_count_q + CNT_W'(1);
            case (state_q)
                ST_IDLE: begin
                    if (bus.frame_start) begin
                        frag_count_q <= '0;
                        overflow_q   <= 1'b0;
                        fill_first_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    fill_first_q <= 1'b0;
                    if (!fill_first_q && bus.src_finished && !bus.frame_start) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (empty_c && !vga_plot_q) begin
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.vga_x      = vga_q.x;
    assign bus.vga_y      = vga_q.y;
    assign bus.vga_colour = vga_q.colour;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = busy_q;
    assign bus.overflow   = overflow_q;
    assign bus.frag_count = frag_count_q;
endmodule
